fifo_level: RTL

- Parametrised synchronous FIFO. Next generation of the team's basic shiftin/shiftout FIFO.
- Adds fill-level output, programmable almost_empty/almost_full thresholds, overflow/underflow error pulses, and a selectable read mode: first-word-fall-through or registered read.
- Used as the general-purpose buffer between streaming producers and consumers in the demo designs.
- Implemented as one register-array memory plus read/write pointers and a level counter.

---
 rtl/fifo_level.sv | 85 ++++++++
 1 files changed

// File: rtl/fifo_level.sv
// Synchronous FIFO with fill level, programmable almost flags, overflow/underflow
// pulses and a selectable first-word-fall-through or registered read port.
module fifo_level #(
  parameter int DWIDTH    = 32,
  parameter int AWIDTH    = 3,
  parameter int AEMPTY_TH = 1,
  parameter int AFULL_TH  = 1,
  parameter int FWFT      = 1
) (
  input  logic              clk,
  input  logic              res_n,
  input  logic              shiftin,
  input  logic [DWIDTH-1:0] data_in,
  input  logic              shiftout,
  output logic [DWIDTH-1:0] data_out,
  output logic              empty,
  output logic              full,
  output logic              almost_empty,
  output logic              almost_full,
  output logic [AWIDTH:0]   level,
  output logic              overflow,
  output logic              underflow
);

  localparam int DEPTH = 1 << AWIDTH;
  localparam logic [AWIDTH:0] AE_LVL = (AWIDTH+1)'(AEMPTY_TH);
  localparam logic [AWIDTH:0] AF_LVL = (AWIDTH+1)'(DEPTH - AFULL_TH);

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [AWIDTH-1:0] wr_ptr;
  logic [AWIDTH-1:0] rd_ptr;
  logic              rd_ok;
  logic              wr_ok;
  logic [AWIDTH:0]   level_nxt;

  // A full FIFO still accepts a write when the same edge pops a word.
  always_comb begin
    rd_ok     = shiftout & ~empty;
    wr_ok     = shiftin & (~full | rd_ok);
    level_nxt = level + (AWIDTH+1)'(wr_ok) - (AWIDTH+1)'(rd_ok);
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= (AFULL_TH >= DEPTH);
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      level        <= level_nxt;
      empty        <= (level_nxt == '0);
      full         <= (level_nxt == (AWIDTH+1)'(DEPTH));
      almost_empty <= (level_nxt <= AE_LVL);
      almost_full  <= (level_nxt >= AF_LVL);
      overflow     <= shiftin & ~wr_ok;
      underflow    <= shiftout & empty;
    end
  end

  // Storage carries no reset; contents are only meaningful below the level count.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= data_in;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign data_out = mem[rd_ptr];
    end else begin : g_reg
      logic [DWIDTH-1:0] dout_p0;
      always_ff @(posedge clk or negedge res_n) begin
        if (!res_n)     dout_p0 <= '0;
        else if (rd_ok) dout_p0 <= mem[rd_ptr];
      end
      assign data_out = dout_p0;
    end
  endgenerate

endmodule
